mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single-port unified memory between the fetch stage (instruction reads) and the execute stage (LDR/STR). It arbitrates requests, sequences one memory transaction at a time, and returns read data to the owner. It raises the stall signals that hold fetch or execute while the port is busy. It also drops in-flight fetch responses when execute flushes on a taken branch.

Parameters:
MEM_LAT, 2, cycles from the memory issue cycle to valid mem_rdata_i (>=1)
STARVE_MAX, 3, consecutive lost contentions after which fetch gets priority (>=1)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
if_req_i  in  1  fetch read request
if_addr_i  in  32  fetch address
if_gnt_o  out  1  fetch request accepted this cycle
if_rdata_o  out  32  instruction word
if_valid_o  out  1  if_rdata_o valid, 1-cycle pulse
ls_req_i  in  1  execute load/store request
ls_we_i  in  1  1 = store
ls_addr_i  in  32  load/store address
ls_wdata_i  in  32  store data
ls_gnt_o  out  1  load/store accepted this cycle
ls_rdata_o  out  32  load data
ls_valid_o  out  1  load/store complete, 1-cycle pulse
flush_i  in  1  branch flush from execute; discard outstanding fetch
mem_en_o  out  1  memory access strobe
mem_we_o  out  1  memory write enable
mem_addr_o  out  32  memory address
mem_wdata_o  out  32  memory write data
mem_rdata_i  in  32  memory read data
if_stall_o  out  1  fetch must hold
ls_stall_o  out  1  execute must hold

Behaviour:
- FSM states: IDLE, BUSY. Only one transaction is outstanding at a time.
- IDLE grant (combinational):
  - Only ls requesting: grant ls.
  - Only if requesting: grant if.
  - Both requesting: grant ls, unless starve_cnt == STARVE_MAX, then grant if.
  - if_req_i is ignored in any cycle where flush_i=1.
- Grant cycle T:
  - Assert exactly one of if_gnt_o/ls_gnt_o, and mem_en_o=1.
  - mem_addr_o, mem_we_o and mem_wdata_o come from the winner; mem_we_o=0 for fetch.
  - Record the owner and go to BUSY. Load lat_cnt=0.
- Outside grant cycles: mem_en_o, mem_we_o, mem_addr_o and mem_wdata_o are 0.
- BUSY:
  - lat_cnt increments each cycle.
  - At cycle T+MEM_LAT, sample mem_rdata_i into the owner's rdata register.
  - Return to IDLE.
- Response at cycle T+MEM_LAT+1:
  - The owner's valid_o pulses for 1 cycle. New grants are allowed in that same cycle.
  - Peak rate is one transaction per MEM_LAT+1 cycles.
  - Stores pulse ls_valid_o with ls_rdata_o=0.
  - rdata outputs hold their last value between pulses.
- starve_cnt (3-bit):
  - In an IDLE cycle with both requesting and ls granted: increment, saturating at STARVE_MAX.
  - On an if grant: clear to 0.
  - Otherwise: hold.
- Flush:
  - flush_i=1 in any cycle T..T+MEM_LAT while fetch owns the port sets a discard flag.
  - The memory cycle still completes. if_valid_o stays 0 and if_rdata_o is not updated.
  - flush_i in the response cycle does not retract an if_valid_o already asserted.
  - flush_i never affects ls transactions.
- Requesters hold addr/data stable from request through grant. Dropping req after grant does not cancel the response.
- Stalls (combinational):
  - if_stall_o = if_req_i & ~if_gnt_o.
  - ls_stall_o = ls_req_i & ~ls_valid_o.
- Reset:
  - FSM goes to IDLE; starve_cnt, lat_cnt and the discard flag clear.
  - All registered outputs reset to 0.
  - Reset mid-transaction aborts it with no valid pulse.
  - Combinational outputs are 0 while reset_i=1.

Test Plan:
(All scenarios use MEM_LAT=2, STARVE_MAX=3.)
1. Lone fetch: if_req=1, addr=0x40 at cycle 0; memory returns 0xE3A01005 at cycle 2.
   -> if_gnt=1 and mem_en=1 with mem_addr=0x40 at cycle 0; if_valid=1 with if_rdata=0xE3A01005 at cycle 3.
2. Store: ls_req=1, we=1, addr=0x100, wdata=0xDEADBEEF.
   -> mem_we=1 with matching addr/data in the grant cycle; ls_valid=1 with ls_rdata=0 three cycles later; ls_stall=1 until then.
3. Contention: if_req and ls_req held high continuously.
   -> Grants in order ls, ls, ls, if, ls… (if wins the 4th contention); if_stall=1 in every non-grant cycle.
4. Flush: fetch granted at cycle 0, flush_i=1 at cycle 1.
   -> mem_en pulses at cycle 0; no if_valid at cycle 3; a new ls grant is accepted at cycle 3.
5. Reset: reset_i=1 at cycle 1 after a load grant at cycle 0.
   -> No ls_valid; all outputs 0; next request granted in the first cycle after reset_i deasserts.
6. Back-to-back loads: ls_req held high, addresses 0x10 then 0x14.
   -> Grants at cycles 0 and 3; ls_valid at cycles 3 and 6, each with the matching data.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and load/store. One transaction is in flight at a time. Load/store normally
// wins contention, but fetch is promoted after STARVE_MAX consecutive losses.
// A branch flush while a fetch is outstanding drops that fetch's response.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic [31:0] if_rdata_o,
  output logic        if_valid_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic [31:0] ls_rdata_o,
  output logic        ls_valid_o,
  input  logic        flush_i,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        if_stall_o,
  output logic        ls_stall_o
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             r_state;
  logic [2:0]         r_starve;
  logic [LAT_W-1:0]   r_lat;
  logic               r_owner_ls;
  logic               r_owner_we;
  logic               r_discard;
  logic               r_if_valid;
  logic               r_ls_valid;
  logic [31:0]        r_if_rdata;
  logic [31:0]        r_ls_rdata;

  logic w_if_eff;
  logic w_idle;
  logic w_starved;
  logic w_gnt_ls;
  logic w_gnt_if;
  logic w_last;

  // A fetch request raised alongside a flush belongs to the wrong path.
  assign w_if_eff  = if_req_i & ~flush_i;
  assign w_idle    = (r_state == S_IDLE);
  assign w_starved = (r_starve == 3'(STARVE_MAX));

  // Grants are combinational so a requester learns acceptance in its request cycle.
  assign w_gnt_ls = ~reset_i & w_idle & ls_req_i & ~(w_if_eff & w_starved);
  assign w_gnt_if = ~reset_i & w_idle & w_if_eff & ~w_gnt_ls;

  // Final busy cycle: memory data is valid now and is captured at this edge.
  assign w_last = (r_state == S_BUSY) & (r_lat == LAT_W'(MEM_LAT - 1));

  assign if_gnt_o    = w_gnt_if;
  assign ls_gnt_o    = w_gnt_ls;
  assign mem_en_o    = w_gnt_if | w_gnt_ls;
  assign mem_we_o    = w_gnt_ls & ls_we_i;
  assign mem_addr_o  = w_gnt_ls ? ls_addr_i : (w_gnt_if ? if_addr_i : 32'h0);
  assign mem_wdata_o = w_gnt_ls ? ls_wdata_i : 32'h0;

  assign if_valid_o  = r_if_valid;
  assign if_rdata_o  = r_if_rdata;
  assign ls_valid_o  = r_ls_valid;
  assign ls_rdata_o  = r_ls_rdata;

  // Execute is held until its own completion pulse, not just its grant.
  assign if_stall_o  = ~reset_i & if_req_i & ~w_gnt_if;
  assign ls_stall_o  = ~reset_i & ls_req_i & ~r_ls_valid;

  // Transaction sequencer, starvation counter and response registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= S_IDLE;
      r_starve   <= 3'd0;
      r_lat      <= '0;
      r_owner_ls <= 1'b0;
      r_owner_we <= 1'b0;
      r_discard  <= 1'b0;
      r_if_valid <= 1'b0;
      r_ls_valid <= 1'b0;
      r_if_rdata <= 32'h0;
      r_ls_rdata <= 32'h0;
    end else begin
      r_if_valid <= 1'b0;
      r_ls_valid <= 1'b0;

      if (w_gnt_if) begin
        r_starve <= 3'd0;
      end else if (w_gnt_ls && w_if_eff && !w_starved) begin
        r_starve <= r_starve + 3'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_gnt_ls || w_gnt_if) begin
            r_state    <= S_BUSY;
            r_lat      <= '0;
            r_owner_ls <= w_gnt_ls;
            r_owner_we <= w_gnt_ls & ls_we_i;
            r_discard  <= 1'b0;
          end
        end
        S_BUSY: begin
          r_lat <= r_lat + LAT_W'(1);
          if (!r_owner_ls && flush_i) begin
            r_discard <= 1'b1;
          end
          if (w_last) begin
            r_state <= S_IDLE;
            if (r_owner_ls) begin
              r_ls_valid <= 1'b1;
              r_ls_rdata <= r_owner_we ? 32'h0 : mem_rdata_i;
            end else if (!(r_discard || flush_i)) begin
              r_if_valid <= 1'b1;
              r_if_rdata <= mem_rdata_i;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by a randomized run,
// every cycle compared against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 3;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic [31:0] if_rdata_o;
  logic        if_valid_o;
  logic        ls_req_i;
  logic        ls_we_i;
  logic [31:0] ls_addr_i;
  logic [31:0] ls_wdata_i;
  logic        ls_gnt_o;
  logic [31:0] ls_rdata_o;
  logic        ls_valid_o;
  logic        flush_i;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        if_stall_o;
  logic        ls_stall_o;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o), .ls_rdata_o(ls_rdata_o),
    .ls_valid_o(ls_valid_o), .flush_i(flush_i),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .if_stall_o(if_stall_o), .ls_stall_o(ls_stall_o)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  // Reference model: absolute cycle numbers, one pending transaction record.
  int          cyc     = 0;
  int          free_at = 0;
  int          starve  = 0;
  bit          pend    = 1'b0;
  bit          p_ls, p_we, p_disc;
  int          p_t;
  logic [31:0] p_data;
  logic [31:0] m_if_rdata = 32'h0;
  logic [31:0] m_ls_rdata = 32'h0;
  bit          e_if_v = 1'b0;
  bit          e_ls_v = 1'b0;
  bit          g_if, g_ls, eif;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Evaluate the current cycle's inputs against the model and compare outputs.
  task automatic sample();
    logic [31:0] e_addr, e_wdata;
    @(negedge clk);
    eif  = if_req_i && !flush_i;
    g_if = 1'b0;
    g_ls = 1'b0;
    if (!reset_i && cyc >= free_at) begin
      if (ls_req_i && !(eif && starve == STARVE_MAX)) g_ls = 1'b1;
      else if (eif)                                   g_if = 1'b1;
    end
    if (pend && !p_ls && flush_i && cyc <= p_t + MEM_LAT) p_disc = 1'b1;
    if (pend && cyc == p_t + MEM_LAT) p_data = mem_rdata_i;
    e_addr  = g_ls ? ls_addr_i : (g_if ? if_addr_i : 32'h0);
    e_wdata = g_ls ? ls_wdata_i : 32'h0;
    if (chk_on) begin
      chkb("if_gnt",    if_gnt_o,    g_if);
      chkb("ls_gnt",    ls_gnt_o,    g_ls);
      chkb("mem_en",    mem_en_o,    g_if | g_ls);
      chkb("mem_we",    mem_we_o,    g_ls & ls_we_i);
      chk ("mem_addr",  mem_addr_o,  e_addr);
      chk ("mem_wdata", mem_wdata_o, e_wdata);
      chkb("if_valid",  if_valid_o,  e_if_v);
      chkb("ls_valid",  ls_valid_o,  e_ls_v);
      chk ("if_rdata",  if_rdata_o,  m_if_rdata);
      chk ("ls_rdata",  ls_rdata_o,  m_ls_rdata);
      chkb("if_stall",  if_stall_o,  !reset_i && if_req_i && !g_if);
      chkb("ls_stall",  ls_stall_o,  !reset_i && ls_req_i && !e_ls_v);
    end
  endtask

  // Advance the model across the clock edge, then release inputs for change.
  task automatic tick();
    @(posedge clk);
    if (reset_i) begin
      pend = 1'b0; free_at = 0; starve = 0;
      e_if_v = 1'b0; e_ls_v = 1'b0;
      m_if_rdata = 32'h0; m_ls_rdata = 32'h0;
    end else begin
      e_if_v = 1'b0;
      e_ls_v = 1'b0;
      if (pend && cyc == p_t + MEM_LAT) begin
        if (p_ls) begin
          e_ls_v = 1'b1;
          m_ls_rdata = p_we ? 32'h0 : p_data;
        end else if (!p_disc) begin
          e_if_v = 1'b1;
          m_if_rdata = p_data;
        end
        pend = 1'b0;
      end
      if (g_ls || g_if) begin
        pend = 1'b1; p_ls = g_ls; p_we = g_ls && ls_we_i; p_disc = 1'b0;
        p_t = cyc; free_at = cyc + MEM_LAT + 1;
      end
      if (g_if) starve = 0;
      else if (g_ls && eif && starve < STARVE_MAX) starve++;
    end
    cyc++;
    #1;
  endtask

  task automatic quiet(input int n);
    if_req_i = 1'b0; ls_req_i = 1'b0; ls_we_i = 1'b0; flush_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_rdata_i = $urandom;
      sample();
      tick();
    end
  endtask

  bit exp_ls_seq [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    reset_i = 1'b1; if_req_i = 1'b0; if_addr_i = 32'h0; ls_req_i = 1'b0;
    ls_we_i = 1'b0; ls_addr_i = 32'h0; ls_wdata_i = 32'h0; flush_i = 1'b0;
    mem_rdata_i = 32'h0;
    sample(); tick();
    chk_on = 1'b1;
    sample(); tick();
    reset_i = 1'b0;
    quiet(2);

    // Lone fetch
    if_req_i = 1'b1; if_addr_i = 32'h40; mem_rdata_i = 32'hE3A01005;
    sample(); chkb("s1_if_gnt", if_gnt_o, 1'b1); chk("s1_addr", mem_addr_o, 32'h40); tick();
    if_req_i = 1'b0;
    sample(); tick();
    sample(); tick();
    sample(); chkb("s1_if_valid", if_valid_o, 1'b1); chk("s1_if_rdata", if_rdata_o, 32'hE3A01005); tick();
    quiet(3);

    // Store
    ls_req_i = 1'b1; ls_we_i = 1'b1; ls_addr_i = 32'h100; ls_wdata_i = 32'hDEADBEEF;
    sample(); chkb("s2_we", mem_we_o, 1'b1); chk("s2_addr", mem_addr_o, 32'h100);
    chk("s2_wdata", mem_wdata_o, 32'hDEADBEEF); tick();
    sample(); chkb("s2_stall1", ls_stall_o, 1'b1); tick();
    sample(); chkb("s2_stall2", ls_stall_o, 1'b1); tick();
    sample(); chkb("s2_valid", ls_valid_o, 1'b1); chk("s2_rdata", ls_rdata_o, 32'h0);
    chkb("s2_stall3", ls_stall_o, 1'b0); tick();
    quiet(4);

    // Contention
    if_req_i = 1'b1; if_addr_i = 32'h200; ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h300;
    for (int k = 0; k < 15; k++) begin
      mem_rdata_i = $urandom;
      sample();
      if (k % 3 == 0) begin
        chkb("s3_ls_gnt", ls_gnt_o, exp_ls_seq[k/3]);
        chkb("s3_if_gnt", if_gnt_o, !exp_ls_seq[k/3]);
      end else begin
        chkb("s3_if_stall", if_stall_o, 1'b1);
      end
      tick();
    end
    quiet(4);

    // Flush of an outstanding fetch
    if_req_i = 1'b1; if_addr_i = 32'h80; mem_rdata_i = 32'h12345678;
    sample(); chkb("s4_if_gnt", if_gnt_o, 1'b1); tick();
    if_req_i = 1'b0; flush_i = 1'b1;
    sample(); chkb("s4_mem_en", mem_en_o, 1'b0); tick();
    flush_i = 1'b0;
    sample(); tick();
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h90;
    sample(); chkb("s4_no_if_valid", if_valid_o, 1'b0); chkb("s4_ls_gnt", ls_gnt_o, 1'b1); tick();
    quiet(4);

    // Reset mid-transaction
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'hA0;
    sample(); chkb("s5_gnt", ls_gnt_o, 1'b1); tick();
    reset_i = 1'b1;
    sample(); chkb("s5_rst_stall", ls_stall_o, 1'b0); chkb("s5_rst_en", mem_en_o, 1'b0); tick();
    reset_i = 1'b0;
    sample(); chkb("s5_regnt", ls_gnt_o, 1'b1); chkb("s5_no_valid", ls_valid_o, 1'b0); tick();
    ls_req_i = 1'b0;
    quiet(4);

    // Back-to-back loads
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h10;
    for (int k = 0; k < 7; k++) begin
      mem_rdata_i = (k == 2) ? 32'h11112222 : (k == 5) ? 32'h33334444 : $urandom;
      if (k == 1) ls_addr_i = 32'h14;
      if (k == 4) ls_req_i = 1'b0;
      sample();
      if (k == 0) chk("s6_addr0", mem_addr_o, 32'h10);
      if (k == 3) begin
        chkb("s6_gnt1", ls_gnt_o, 1'b1); chk("s6_addr1", mem_addr_o, 32'h14);
        chkb("s6_valid0", ls_valid_o, 1'b1); chk("s6_data0", ls_rdata_o, 32'h11112222);
      end
      if (k == 6) begin
        chkb("s6_valid1", ls_valid_o, 1'b1); chk("s6_data1", ls_rdata_o, 32'h33334444);
      end
      tick();
    end
    quiet(3);

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      reset_i     = ($urandom_range(0, 59) == 0);
      if_req_i    = 1'($urandom_range(0, 1));
      ls_req_i    = 1'($urandom_range(0, 1));
      ls_we_i     = 1'($urandom_range(0, 1));
      flush_i     = ($urandom_range(0, 5) == 0);
      if_addr_i   = $urandom;
      ls_addr_i   = $urandom;
      ls_wdata_i  = $urandom;
      mem_rdata_i = $urandom;
      sample();
      tick();
    end
    reset_i = 1'b0;
    quiet(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
